iomem_arbiter: RTL and testbench
================================

Name: iomem_arbiter

Overview:
- Shares one iomem slave bus (GPIO and other memory-mapped peripherals) between two masters: m0 (the PicoSoC CPU iomem port) and m1 (a second requester such as a UART debug bridge or a DMA).
- Each transaction gets a round-robin grant and is forwarded to the slave unchanged.
- A bus-timeout watchdog completes any access the slave never acknowledges, so neither master can hang.

Parameters:
- TIMEOUT, 255: number of cycles in BUSY without s_ready before a forced completion. Legal range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on a timed-out access.

Ports:
- clk_pll  in  1  system clock
- resetn  in  1  reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 completion pulse (1 cycle)
- m0_wstrb  in  4  byte write strobes; 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_rdata  out  32  read data; valid when m0_ready=1
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same as m0, for master 1
- s_valid  out  1  request to slave bus
- s_ready  in  1  slave completion
- s_wstrb  out  4  forwarded strobes
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_rdata  in  32  slave read data
- timeout_pulse  out  1  one-cycle pulse on each forced completion
- err_count  out  8  saturating count of timeouts

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk_pll. While resetn=0 the following hold:
  - state=IDLE, grant=0, last=1 (so m0 wins the first tie), timer=0, err_count=0.
  - All ready outputs, s_valid and timeout_pulse are 0.
  - Reset mid-transaction drops s_valid on the next edge with no ready pulse. The in-flight access is lost.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - s_valid=0.
  - Exactly one of m0_valid/m1_valid is high: latch grant to that master, go to BUSY.
  - Both are high: grant = !last, then go to BUSY.
  - Neither is high: stay in IDLE.
- BUSY:
  - s_valid=1. s_wstrb, s_addr and s_wdata are combinationally muxed from the granted master.
  - timer increments each cycle.
  - s_ready=1: the granted mN_ready=1 and mN_rdata=s_rdata in the same cycle (combinational pass-through). Then last<=grant, timer<=0, go to DONE.
  - s_ready=0 and timer==TIMEOUT-1: the granted mN_ready=1, mN_rdata=ERR_DATA, timeout_pulse=1, err_count increments (holds at 255). Then last<=grant, go to DONE.
  - Granted master drops valid before completion (protocol violation): abort to IDLE with no ready pulse, timer<=0.
- DONE:
  - One dead cycle with s_valid=0 and no ready pulses. This lets the master deassert valid, so the slave never sees a stale back-to-back request.
  - Always returns to IDLE.
- Timing: latency from request to first s_valid is 1 cycle. Minimum transaction is 3 cycles: IDLE, BUSY with s_ready, DONE.
- The non-granted master's ready is always 0 and its rdata is 0. rdata outputs are 0 whenever ready=0.
- s_ready arriving while not in BUSY is ignored.
- A request on the non-granted master during BUSY stays pending. It is served on the next IDLE arbitration.
- Fairness: with both masters continuously requesting, grants strictly alternate m0, m1, m0, ...
- The timer is 16 bits and clears on entry to BUSY.

Decomposition:
- Shared package iomem_pkg holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the ERR_DATA default constant;
  - iomem field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
- One natural sub-module, iomem_timeout_ctr, containing the timer and saturating err_count. Its interface is clear/enable in and expire/pulse out.
- Arbitration and muxing stay in the top.

Test Plan:
- m0 only, write addr 0x0300_0000, wdata 0x0000_00A5, wstrb 4'hF; slave acks 2 cycles into BUSY -> s_addr/s_wdata match; m0_ready pulses once; m1_ready stays 0; next cycle s_valid=0.
- m1 only, read 0x0300_0000; slave returns 0x1234_5678 -> m1_rdata=0x1234_5678 exactly in the cycle m1_ready=1; m0_rdata=0.
- Both masters request continuously for 6 transactions, slave acks immediately -> grant order m0,m1,m0,m1,m0,m1; each transaction 3 cycles; no simultaneous readies.
- TIMEOUT=8, slave never acks -> m0_ready on the 8th BUSY cycle with rdata 0xDEAD_BEEF; timeout_pulse=1 for 1 cycle; err_count=1. Repeating 300 times gives err_count=255 (saturated).
- resetn low for 1 cycle during BUSY -> next cycle s_valid=0, no ready pulses, err_count=0. After resetn=1 with both masters valid, m0 is granted first.
- m0 drops valid mid-BUSY -> FSM back to IDLE; no m0_ready; a pending m1 request is granted on the following cycle.

Source files
------------

// File: rtl/iomem_pkg.sv
// -----------------------------------------------------------------------------
// iomem_pkg
// Shared definitions for the iomem arbiter slice: bus field widths, the FSM
// state encoding and the default read data returned on a timed-out access.
// -----------------------------------------------------------------------------
package iomem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // rdata handed back to a master whose access the slave never acknowledged
    localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

endpackage : iomem_pkg

// File: rtl/iomem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// iomem_timeout_ctr
// Bus watchdog: a 16-bit cycle timer plus a saturating 8-bit count of
// forced completions.
//   clk_pll      in   system clock
//   resetn       in   synchronous active-low reset
//   clr_i        in   force timer to zero (has priority over en_i)
//   en_i         in   count one cycle of an outstanding access
//   expire_o     out  timer has reached TIMEOUT-1
//   pulse_o      out  forced completion happens this cycle
//   err_count_o  out  saturating number of forced completions
// -----------------------------------------------------------------------------
module iomem_timeout_ctr
    import iomem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_pll,
    input  logic       resetn,
    input  logic       clr_i,
    input  logic       en_i,
    output logic       expire_o,
    output logic       pulse_o,
    output logic [7:0] err_count_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] timer_q;
    logic [15:0] timer_d;
    logic [7:0]  err_q;
    logic [7:0]  err_d;

    assign expire_o    = (timer_q == TMO_LAST);
    // An expiry only counts while the access is still live (not being cleared)
    assign pulse_o     = en_i & ~clr_i & expire_o;
    assign err_count_o = err_q;

    // Next-state for the cycle timer and the saturating error counter
    always_comb begin
        timer_d = timer_q;
        err_d   = err_q;
        if (clr_i) begin
            timer_d = 16'd0;
        end else if (en_i) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end
        if (pulse_o && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Timer and error counter registers
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            timer_q <= 16'd0;
            err_q   <= 8'd0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

endmodule : iomem_timeout_ctr

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
// Round-robin arbiter sharing one iomem slave bus between two masters, with a
// watchdog that force-completes accesses the slave never acknowledges.
//   clk_pll, resetn                     clock, synchronous active-low reset
//   m0_* / m1_*                         master request ports (valid held until
//                                       ready; ready/rdata are 1-cycle pulses)
//   s_valid/s_wstrb/s_addr/s_wdata      forwarded request to the slave
//   s_ready/s_rdata                     slave completion and read data
//   timeout_pulse                       one cycle per forced completion
//   err_count                           saturating count of timeouts
// Each access runs IDLE -> BUSY -> DONE; DONE is a dead cycle so a master
// has time to drop valid before the next arbitration.
// -----------------------------------------------------------------------------
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic              clk_pll,
    input  logic              resetn,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [STRB_W-1:0] s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              timeout_pulse,
    output logic [7:0]        err_count
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;   // 0 = m0, 1 = m1
    logic              last_q,  last_d;    // master served by the last completion
    logic              busy_s;
    logic              gnt_valid_s;
    logic              expire_s;
    logic              done_s;
    logic [DATA_W-1:0] rdata_s;

    assign busy_s      = (state_q == ST_BUSY);
    assign gnt_valid_s = grant_q ? m1_valid : m0_valid;

    iomem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_pll     (clk_pll),
        .resetn      (resetn),
        // Timer only runs while a live, unacknowledged access is outstanding
        .clr_i       (~busy_s | s_ready | ~gnt_valid_s),
        .en_i        (busy_s),
        .expire_o    (expire_s),
        .pulse_o     (timeout_pulse),
        .err_count_o (err_count)
    );

    // Arbitration, next-state and slave-side request muxing
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        s_valid = 1'b0;
        s_wstrb = 4'h0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        done_s  = 1'b0;
        rdata_s = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    grant_d = ~last_q;
                    state_d = ST_BUSY;
                end else if (m0_valid) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (m1_valid) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                s_valid = 1'b1;
                if (grant_q) begin
                    s_wstrb = m1_wstrb;
                    s_addr  = m1_addr;
                    s_wdata = m1_wdata;
                end else begin
                    s_wstrb = m0_wstrb;
                    s_addr  = m0_addr;
                    s_wdata = m0_wdata;
                end
                // A master abandoning its request wins over any completion
                if (!gnt_valid_s) begin
                    state_d = ST_IDLE;
                end else if (s_ready) begin
                    done_s  = 1'b1;
                    rdata_s = s_rdata;
                    last_d  = grant_q;
                    state_d = ST_DONE;
                end else if (expire_s) begin
                    done_s  = 1'b1;
                    rdata_s = ERR_DATA;
                    last_d  = grant_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion is steered only to the granted master; rdata is 0 otherwise
    assign m0_ready = done_s & ~grant_q;
    assign m1_ready = done_s &  grant_q;
    assign m0_rdata = m0_ready ? rdata_s : 32'h0;
    assign m1_rdata = m1_ready ? rdata_s : 32'h0;

    // FSM, grant and round-robin history registers
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule : iomem_arbiter

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

    logic        clk_pll = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready, timeout_pulse;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  err_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    iomem_arbiter #(.TIMEOUT(8)) dut (
        .clk_pll(clk_pll), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .timeout_pulse(timeout_pulse), .err_count(err_count)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // advance one clock; outputs are settled 2 time units after the edge
    task automatic step();
        @(posedge clk_pll);
        #2;
    endtask

    initial begin
        int npulse;
        resetn = 1'b0;
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready = 1'b0;  s_rdata = 32'h0;
        step(); step();
        chk("rst_s_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_m0_ready", {31'h0, m0_ready}, 32'h0);
        chk("rst_m1_ready", {31'h0, m1_ready}, 32'h0);
        chk("rst_tmo_pulse", {31'h0, timeout_pulse}, 32'h0);
        chk("rst_err_count", {24'h0, err_count}, 32'h0);
        resetn = 1'b1;
        step();

        // ---- m0 write, slave acks in the second BUSY cycle ----
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wdata = 32'h0000_00A5; m0_wstrb = 4'hF;
        #1 chk("t1_idle_s_valid", {31'h0, s_valid}, 32'h0);
        step();
        chk("t1_s_valid", {31'h0, s_valid}, 32'h1);
        chk("t1_s_addr", s_addr, 32'h0300_0000);
        chk("t1_s_wdata", s_wdata, 32'h0000_00A5);
        chk("t1_s_wstrb", {28'h0, s_wstrb}, 32'hF);
        chk("t1_no_early_ready", {31'h0, m0_ready}, 32'h0);
        step();
        s_ready = 1'b1;
        #1 chk("t1_m0_ready", {31'h0, m0_ready}, 32'h1);
        chk("t1_m1_ready", {31'h0, m1_ready}, 32'h0);
        step();
        s_ready = 1'b0; m0_valid = 1'b0;
        #1 chk("t1_done_s_valid", {31'h0, s_valid}, 32'h0);
        chk("t1_done_m0_ready", {31'h0, m0_ready}, 32'h0);
        step();

        // ---- m1 read, slave returns 0x1234_5678 ----
        m1_valid = 1'b1; m1_addr = 32'h0300_0000; m1_wstrb = 4'h0;
        step();
        s_rdata = 32'h1234_5678;
        #1 chk("t2_rdata_hidden", m1_rdata, 32'h0);
        s_ready = 1'b1;
        #1 chk("t2_m1_ready", {31'h0, m1_ready}, 32'h1);
        chk("t2_m1_rdata", m1_rdata, 32'h1234_5678);
        chk("t2_m0_rdata", m0_rdata, 32'h0);
        chk("t2_m0_ready", {31'h0, m0_ready}, 32'h0);
        step();
        s_ready = 1'b0; m1_valid = 1'b0;
        step();

        // ---- both masters continuously requesting, immediate ack ----
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_m0_ready", {31'h0, m0_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_m1_ready", {31'h0, m1_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("t3_s_addr", s_addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            step();
            chk("t3_done_s_valid", {31'h0, s_valid}, 32'h0);
            chk("t3_done_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
            step();
            chk("t3_idle_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
        end
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        step();

        // ---- timeout: slave never acks (TIMEOUT=8) ----
        m0_valid = 1'b1; m0_wstrb = 4'h0;
        step();
        for (int i = 1; i < 8; i++) begin
            chk("t4_no_ready", {31'h0, m0_ready}, 32'h0);
            step();
        end
        chk("t4_m0_ready", {31'h0, m0_ready}, 32'h1);
        chk("t4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t4_tmo_pulse", {31'h0, timeout_pulse}, 32'h1);
        step();
        chk("t4_pulse_gone", {31'h0, timeout_pulse}, 32'h0);
        chk("t4_err_count", {24'h0, err_count}, 32'h1);
        // 299 more timeouts with m0 held valid
        npulse = 0;
        for (int c = 0; c < 4000 && npulse < 299; c++) begin
            step();
            if (timeout_pulse) npulse++;
        end
        chk("t4_repeat_cnt", npulse, 32'd299);
        step();
        m0_valid = 1'b0;
        chk("t4_err_sat", {24'h0, err_count}, 32'd255);
        step();

        // ---- reset during BUSY ----
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        step();
        chk("t5_busy", {31'h0, s_valid}, 32'h1);
        resetn = 1'b0;
        step();
        chk("t5_s_valid", {31'h0, s_valid}, 32'h0);
        chk("t5_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
        chk("t5_err_count", {24'h0, err_count}, 32'h0);
        resetn = 1'b1; m1_valid = 1'b1;
        step();
        chk("t5_first_gnt_addr", s_addr, 32'h0000_0100);
        s_ready = 1'b1;
        #1 chk("t5_m0_ready", {31'h0, m0_ready}, 32'h1);
        chk("t5_m1_ready", {31'h0, m1_ready}, 32'h0);
        step();
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        step();

        // ---- m0 abandons its request, pending m1 then served ----
        m0_valid = 1'b1;
        step();
        m1_valid = 1'b1;
        step();
        chk("t6_still_m0", s_addr, 32'h0000_0100);
        m0_valid = 1'b0;
        #1 chk("t6_no_m0_ready", {31'h0, m0_ready}, 32'h0);
        step();
        chk("t6_idle_s_valid", {31'h0, s_valid}, 32'h0);
        step();
        chk("t6_m1_s_valid", {31'h0, s_valid}, 32'h1);
        chk("t6_m1_addr", s_addr, 32'h0000_0200);
        s_ready = 1'b1;
        #1 chk("t6_m1_ready", {31'h0, m1_ready}, 32'h1);
        chk("t6_m0_ready", {31'h0, m0_ready}, 32'h0);
        step();
        s_ready = 1'b0; m1_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_iomem_arbiter
